// File: rtl/winograd_hadamard_unit.sv
// Winograd F(4x4,3x3) elementwise (Hadamard) multiply stage.
// Snapshots the transformed input tile U and kernel V on start, then writes
// one 6-element row of U.*V per cycle into matrix_out, optionally adding
// into the previous contents so multiple input channels can be summed in
// the transform domain before the reverse transform.
module winograd_hadamard_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TILE       = 6
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         accumulate,
    input  logic [0:TILE-1][0:TILE-1][DATA_WIDTH-1:0]    matrix_u,
    input  logic [0:TILE-1][0:TILE-1][DATA_WIDTH-1:0]    matrix_v,
    output logic [0:TILE-1][0:TILE-1][DATA_WIDTH-1:0]    matrix_out,
    output logic                                         busy,
    output logic                                         done
);

    localparam int unsigned ROW_W = $clog2(TILE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                                      r_state;
    state_t                                      w_state_nxt;
    logic                                        w_load;
    logic                                        w_row_en;
    logic                                        w_busy_nxt;
    logic                                        w_done_nxt;
    logic [ROW_W-1:0]                            r_row;
    logic [ROW_W-1:0]                            w_row_nxt;
    logic                                        r_busy;
    logic                                        r_done;
    logic                                        r_acc;
    logic [0:TILE-1][0:TILE-1][DATA_WIDTH-1:0]   r_u;
    logic [0:TILE-1][0:TILE-1][DATA_WIDTH-1:0]   r_v;
    logic [0:TILE-1][0:TILE-1][DATA_WIDTH-1:0]   r_out;
    logic [0:TILE-1][DATA_WIDTH-1:0]             w_prod;
    logic [0:TILE-1][DATA_WIDTH-1:0]             w_row_val;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control; busy/done are computed one cycle
    // ahead so the registered flags line up exactly with CALC and DONE
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_row_en    = 1'b0;
        w_row_nxt   = r_row;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_row_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_row_en = 1'b1;
                if (r_row == LAST_ROW) begin
                    w_row_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_row_nxt   = r_row + ROW_W'(1);
                    w_busy_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Row counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_row  <= w_row_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Job snapshot so later input changes cannot disturb a running job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_u   <= '0;
            r_v   <= '0;
            r_acc <= 1'b0;
        end else if (w_load) begin
            r_u   <= matrix_u;
            r_v   <= matrix_v;
            r_acc <= accumulate;
        end
    end

    // Six signed multipliers for the current row; only the low DATA_WIDTH
    // bits are kept, which wrap identically for signed operands
    always_comb begin
        w_prod    = '0;
        w_row_val = '0;
        for (int unsigned c = 0; c < TILE; c++) begin
            w_prod[c]    = DATA_WIDTH'($signed(r_u[r_row][c]) * $signed(r_v[r_row][c]));
            w_row_val[c] = r_acc ? DATA_WIDTH'(r_out[r_row][c] + w_prod[c]) : w_prod[c];
        end
    end

    // Result register; only the row being computed is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_row_en) begin
            r_out[r_row] <= w_row_val;
        end
    end

    assign matrix_out = r_out;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: doc/winograd_hadamard_unit.md
WINOGRAD_HADAMARD_UNIT -- requirements
Module: winograd_hadamard_unit

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, element width of all matrix ports.
REQ-002 SHALL have parameter: TILE, 6, matrix dimension; only 6 is supported (F(4x4,3x3) tile).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: start  input  1  request one elementwise-multiply job; sampled only in IDLE.
REQ-006 SHALL have port: accumulate  input  1  sampled with start; 1 = add products to matrix_out, 0 = overwrite matrix_out.
REQ-007 SHALL have port: matrix_u  input  [0:5][0:5] x DATA_WIDTH  transformed input tile (B^T d B), signed two's complement.
REQ-008 SHALL have port: matrix_v  input  [0:5][0:5] x DATA_WIDTH  transformed kernel (G g G^T), signed two's complement.
REQ-009 SHALL have port: matrix_out  output  [0:5][0:5] x DATA_WIDTH  registered Hadamard result, feeds reverse transform unit matrix_in.
REQ-010 SHALL have port: busy  output  1  high while rows are being computed.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when matrix_out is complete and stable.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1 at a rising edge, snapshot matrix_u, matrix_v and accumulate into internal registers, clear row counter to 0, and enter CALC.
REQ-014 SHALL ignore start in CALC and DONE; no requeue, no effect on the running job.
REQ-015 SHALL, in CALC, compute one full row per cycle using exactly 6 signed multipliers: row r, col c = U[r][c] * V[r][c] from the snapshot.
REQ-016 SHALL keep the low DATA_WIDTH bits of each 2*DATA_WIDTH product (modulo 2^32 wrap, no saturation).
REQ-017 SHALL, when accumulate snapshot=1, write matrix_out[r][c] + product (modulo 2^32); when 0, write product.
REQ-018 SHALL increment the row counter each CALC cycle and move to DONE on the edge that writes row 5.
REQ-019 SHALL leave rows not yet written holding their previous values during CALC.
REQ-020 SHALL assert busy exactly in CALC (6 cycles) and done exactly in DONE (1 cycle), then return to IDLE.
REQ-021 SHALL achieve latency: start sampled at edge N; rows 0..5 written at edges N+1..N+6; done high from edge N+6 to edge N+7.
REQ-022 SHALL hold matrix_out unchanged from the done pulse until the next accepted start's first row write.
REQ-023 SHALL have no effect from input changes on matrix_u/matrix_v/accumulate after the start edge on the current job.

Reset
REQ-024 SHALL, on rst=1 (asynchronous, any state), force state IDLE, row counter 0, busy 0, done 0, all matrix_out elements 0.
REQ-025 SHALL, when reset asserts mid-CALC, abort the job with no done pulse; first start after rst deasserts SHALL run normally.

Verification
REQ-026 SHALL be verified: assert rst -> busy=0, done=0, all 36 matrix_out = 0, including reset asserted asynchronously between edges.
REQ-027 SHALL be verified: U all 1, V = 1..36 row-major, accumulate=0 -> matrix_out = 1..36; busy high 6 cycles; done single pulse at edge N+6.
REQ-028 SHALL be verified: repeat REQ-027 inputs with accumulate=1 -> matrix_out = 2,4,...,72; then accumulate=0 with U=V=0 -> all 0.
REQ-029 SHALL be verified: U[0][0]=-3,V[0][0]=5 -> -15; U[1][1]=V[1][1]=0x00010000 -> 0; U[2][2]=0x7FFFFFFF,V[2][2]=2 -> 0xFFFFFFFE; U[3][3]=V[3][3]=-7 -> 49.
REQ-030 SHALL be verified: start re-pulsed during CALC and DONE, and U/V changed after start edge -> exactly one done pulse, result from snapshot values only.
REQ-031 SHALL be verified: rst asserted after row 3 write -> outputs 0, no done; next job with U=V=all 2 -> all 4.
